// File: rtl/aha_axi_to_sif_write_data.sv
// AXI4 write burst capture: buffers W beats in a first-word-fall-through FIFO,
// streams them to the SIF write port and returns one B response per burst.
module aha_axi_to_sif_write_data #(
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [7:0]          AWLEN,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [DATA_W-1:0]   SIF_WR_DATA,
  output logic [DATA_W/8-1:0] SIF_WR_STRB,
  output logic                SIF_WR_LAST,
  output logic                SIF_WR_VALID,
  input  logic                SIF_WR_READY
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_W + STRB_W + 1;

  typedef enum logic [1:0] {IDLE, DATA, DRAIN, RESP} state_t;

  state_t            state_reg;
  logic [7:0]        len_reg;
  logic [7:0]        beat_cnt_reg;
  logic              err_reg;
  logic [ID_W-1:0]   bid_reg;
  logic [1:0]        bresp_reg;
  logic              bvalid_reg;
  logic              awready_reg;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_reg;
  logic [PTR_W:0]     rd_ptr_reg;
  logic [ENTRY_W-1:0] head;

  logic fifo_empty;
  logic fifo_full;
  logic w_push;
  logic sif_pop;
  logic beat_final;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign WREADY     = (state_reg == DATA) && !fifo_full;
  assign w_push     = WVALID && WREADY;
  assign beat_final = (beat_cnt_reg == len_reg);

  assign SIF_WR_VALID = !fifo_empty;
  assign sif_pop      = SIF_WR_VALID && SIF_WR_READY;

  // Head is read combinationally so a pushed beat is visible the next cycle;
  // gating with empty keeps stale RAM contents off the port.
  assign head = mem[rd_ptr_reg[PTR_W-1:0]];
  assign {SIF_WR_DATA, SIF_WR_STRB, SIF_WR_LAST} = fifo_empty ? '0 : head;

  assign AWREADY = awready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign BID     = bid_reg;

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= {WDATA, WSTRB, beat_final};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (sif_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
      bid_reg      <= '0;
      bresp_reg    <= 2'b00;
      bvalid_reg   <= 1'b0;
      awready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (AWVALID && awready_reg) begin
            len_reg      <= AWLEN;
            bid_reg      <= AWID;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
            awready_reg  <= 1'b0;
            state_reg    <= DATA;
          end
        end
        DATA: begin
          if (w_push) begin
            // Burst length follows AWLEN; a misplaced WLAST only flags an error.
            err_reg <= err_reg | (WLAST != beat_final);
            if (beat_final) begin
              state_reg <= DRAIN;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= err_reg ? 2'b10 : 2'b00;
            state_reg  <= RESP;
          end
        end
        RESP: begin
          if (BREADY) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aha_axi_to_sif_write_data.sv
// Directed bench: a table of bursts driven through AW/W, checked on SIF and B,
// plus a hand-written mid-burst reset sequence.
module tb_aha_axi_to_sif_write_data;

  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 32;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [ID_W-1:0]   AWID;
  logic [7:0]        AWLEN;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [7:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [DATA_W-1:0] SIF_WR_DATA;
  logic [7:0]        SIF_WR_STRB;
  logic              SIF_WR_LAST;
  logic              SIF_WR_VALID;
  logic              SIF_WR_READY;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  aha_axi_to_sif_write_data #(.DATA_W(DATA_W), .ID_W(ID_W), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .SIF_WR_DATA(SIF_WR_DATA), .SIF_WR_STRB(SIF_WR_STRB), .SIF_WR_LAST(SIF_WR_LAST),
    .SIF_WR_VALID(SIF_WR_VALID), .SIF_WR_READY(SIF_WR_READY)
  );

  // sif_mode: 0 always ready, 1 toggling each cycle, 2 low for sif_hold cycles
  typedef struct {
    int         len;
    logic [3:0] id;
    int         wlast_pos;
    int         sif_mode;
    int         sif_hold;
    int         bready_delay;
    logic [1:0] exp_bresp;
    int         max_lat;      // AW-to-B handshake cycles bound, 0 = unchecked
    int         exp_max_occ;  // expected peak FIFO occupancy, 0 = unchecked
  } burst_t;

  burst_t tbl[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] beat_data(input int b, input int i);
    return {8'hA5, 8'(b), 16'(i), 32'hC0DE0000 ^ 32'(i * 7)};
  endfunction

  function automatic logic [7:0] beat_strb(input int b, input int i);
    return 8'(i * 37 + b * 11 + 1);
  endfunction

  task automatic idle_inputs();
    AWVALID = 0; AWID = 0; AWLEN = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0;
    BREADY = 0; SIF_WR_READY = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_awready"}, 64'(AWREADY), 64'd1);
    check({tag, "_wready"}, 64'(WREADY), 64'd0);
    check({tag, "_bvalid"}, 64'(BVALID), 64'd0);
    check({tag, "_bresp"}, 64'(BRESP), 64'd0);
    check({tag, "_bid"}, 64'(BID), 64'd0);
    check({tag, "_sif_valid"}, 64'(SIF_WR_VALID), 64'd0);
    check({tag, "_sif_last"}, 64'(SIF_WR_LAST), 64'd0);
    check({tag, "_sif_data"}, SIF_WR_DATA, 64'd0);
    check({tag, "_sif_strb"}, 64'(SIF_WR_STRB), 64'd0);
  endtask

  task automatic run_burst(input burst_t r, input int bnum);
    int  cyc = 0;
    bit  aw_done = 0;
    bit  b_done = 0;
    int  w_idx = 0;
    int  pops = 0;
    int  bv_seen = 0;
    int  aw_cyc = 0;
    int  b_cyc = 0;
    int  max_occ = 0;
    while (!b_done && cyc < 400) begin
      @(negedge ACLK);
      AWVALID = !aw_done;
      AWID    = r.id;
      AWLEN   = 8'(r.len);
      WVALID  = aw_done && (w_idx <= r.len);
      WDATA   = beat_data(bnum, w_idx);
      WSTRB   = beat_strb(bnum, w_idx);
      WLAST   = (w_idx == r.wlast_pos);
      case (r.sif_mode)
        1:       SIF_WR_READY = cyc[0];
        2:       SIF_WR_READY = (cyc >= r.sif_hold);
        default: SIF_WR_READY = 1'b1;
      endcase
      BREADY = (bv_seen >= r.bready_delay);
      #1;
      if (aw_done) begin
        check("awready_busy", 64'(AWREADY), 64'd0);
        if (w_idx <= r.len)
          check("wready_vs_occ", 64'(WREADY), 64'((w_idx - pops) < DEPTH));
        else
          check("wready_after_final", 64'(WREADY), 64'd0);
      end
      if (SIF_WR_VALID && SIF_WR_READY) begin
        check("sif_pop_in_range", 64'(pops <= r.len), 64'd1);
        check("sif_data", SIF_WR_DATA, beat_data(bnum, pops));
        check("sif_strb", 64'(SIF_WR_STRB), 64'(beat_strb(bnum, pops)));
        check("sif_last", 64'(SIF_WR_LAST), 64'(pops == r.len));
        pops++;
      end
      if (BVALID) begin
        bv_seen++;
        check("b_after_all_pops", 64'(pops), 64'(r.len + 1));
        check("bid", 64'(BID), 64'(r.id));
        check("bresp", 64'(BRESP), 64'(r.exp_bresp));
        if (BREADY) begin
          b_done = 1;
          b_cyc  = cyc;
        end
      end
      if (AWVALID && AWREADY) begin
        aw_done = 1;
        aw_cyc  = cyc;
      end
      if (WVALID && WREADY) w_idx++;
      if (w_idx - pops > max_occ) max_occ = w_idx - pops;
      cyc++;
    end
    check("burst_completed", 64'(b_done), 64'd1);
    check("beats_accepted", 64'(w_idx), 64'(r.len + 1));
    check("bready_hold_cycles", 64'(bv_seen), 64'(r.bready_delay + 1));
    if (r.max_lat != 0) check("turnaround", 64'(b_cyc - aw_cyc <= r.max_lat), 64'd1);
    if (r.exp_max_occ != 0) check("peak_occupancy", 64'(max_occ), 64'(r.exp_max_occ));
    @(negedge ACLK);
    idle_inputs();
    #1;
    check("awready_after_b", 64'(AWREADY), 64'd1);
    check("single_b", 64'(BVALID), 64'd0);
    check("sif_empty_after", 64'(SIF_WR_VALID), 64'd0);
    $display("burst %0d len=%0d id=%0d pops=%0d cycles=%0d bresp=%0d", bnum, r.len, r.id,
             pops, cyc, r.exp_bresp);
  endtask

  initial begin
    tbl[0] = '{len: 0,  id: 4'd3,  wlast_pos: 0,  sif_mode: 0, sif_hold: 0,  bready_delay: 0,
               exp_bresp: 2'b00, max_lat: 4, exp_max_occ: 0};
    tbl[1] = '{len: 3,  id: 4'd5,  wlast_pos: 3,  sif_mode: 1, sif_hold: 0,  bready_delay: 0,
               exp_bresp: 2'b00, max_lat: 0, exp_max_occ: 0};
    tbl[2] = '{len: 39, id: 4'd9,  wlast_pos: 39, sif_mode: 2, sif_hold: 60, bready_delay: 0,
               exp_bresp: 2'b00, max_lat: 0, exp_max_occ: 32};
    tbl[3] = '{len: 3,  id: 4'd2,  wlast_pos: 2,  sif_mode: 0, sif_hold: 0,  bready_delay: 0,
               exp_bresp: 2'b10, max_lat: 0, exp_max_occ: 0};
    tbl[4] = '{len: 1,  id: 4'd12, wlast_pos: 1,  sif_mode: 0, sif_hold: 0,  bready_delay: 10,
               exp_bresp: 2'b00, max_lat: 0, exp_max_occ: 0};

    idle_inputs();
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    #1;
    check_reset_values("reset");
    ARESETn = 1;
    @(negedge ACLK);
    #1;
    check_reset_values("post_reset");

    for (int k = 0; k < 5; k++) run_burst(tbl[k], k);

    // Mid-burst reset: AWLEN=7, two beats buffered, then reset.
    @(negedge ACLK);
    AWVALID = 1; AWID = 4'd7; AWLEN = 8'd7;
    @(negedge ACLK);
    AWVALID = 0;
    for (int i = 0; i < 2; i++) begin
      WVALID = 1; WDATA = beat_data(100, i); WSTRB = beat_strb(100, i); WLAST = 0;
      @(negedge ACLK);
    end
    WVALID = 0;
    #1;
    check("abort_sif_valid_before", 64'(SIF_WR_VALID), 64'd1);
    check("abort_bid_captured", 64'(BID), 64'd7);
    #2;
    ARESETn = 0;
    #1;
    check_reset_values("abort");
    @(negedge ACLK);
    ARESETn = 1;
    BREADY = 1; SIF_WR_READY = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      #1;
      check("abort_no_b", 64'(BVALID), 64'd0);
      check("abort_no_sif", 64'(SIF_WR_VALID), 64'd0);
    end
    $display("burst 100 aborted by reset after 2 beats");
    idle_inputs();
    run_burst(tbl[0], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aha_axi_to_sif_write_data.md
# aha_axi_to_sif_write_data

AXI4 write-path data capture for the Garnet integration: accepts one AXI4 write burst at a time (AW + W channels), buffers write beats in a synchronous FIFO, streams them to the Simple Interface (SIF) write port under SIF backpressure, and returns a single B response once the final beat has been accepted by SIF. It is the write-direction counterpart of the AXI-to-SIF read-data capture block and sits between the AXI slave port and the SIF write port of the CGRA bridge.

## Interface
- DATA_W, 64, AXI/SIF data width in bits (multiple of 8)
- ID_W, 4, AXI ID width
- FIFO_DEPTH, 32, beat buffer depth (power of 2, ≥ 2)

- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- AWID  in  ID_W  burst ID, captured on AW handshake
- AWLEN  in  8  beats minus one
- AWVALID  in  1  AW valid
- AWREADY  out  1  AW ready
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte strobes
- WLAST  in  1  last-beat marker from master
- WVALID  in  1  W valid
- WREADY  out  1  W ready
- BID  out  ID_W  captured AWID
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- BVALID  out  1  B valid
- BREADY  in  1  B ready
- SIF_WR_DATA  out  DATA_W  FIFO head data
- SIF_WR_STRB  out  DATA_W/8  FIFO head strobes
- SIF_WR_LAST  out  1  head entry is the burst's final beat
- SIF_WR_VALID  out  1  FIFO non-empty
- SIF_WR_READY  in  1  SIF accepts head entry this cycle

## Operation
- FSM states: IDLE, DATA, DRAIN, RESP. Reset → IDLE.
- IDLE: AWREADY=1. On AWVALID&AWREADY: len←AWLEN, BID←AWID, beat_cnt←0, err←0; go DATA.
- DATA: WREADY = ~fifo_full. Each W handshake pushes {WDATA, WSTRB, final} where final=(beat_cnt==len); beat_cnt increments (8-bit, never exceeds len).
- Protocol check on every accepted beat: WLAST != final sets sticky err. Burst length is governed by AWLEN, never by WLAST.
- Handshake on final beat → DRAIN.
- DRAIN: when FIFO empty (last entry popped) → RESP.
- RESP: BVALID=1, BRESP = err ? 2'b10 : 2'b00; held stable until BREADY. On BVALID&BREADY → IDLE.
- SIF side independent of FSM: SIF_WR_VALID = ~empty; pop on SIF_WR_VALID&SIF_WR_READY; outputs are FIFO head (first-word-fall-through).
- Single outstanding burst: AWREADY=0 outside IDLE; WREADY=0 outside DATA.
- Full: WREADY=0, no push. Empty: SIF_WR_VALID=0, SIF_WR_READY ignored. Simultaneous push and pop when full or empty: both legal when FIFO is neither full nor empty; when full, pop this cycle does not enable push this cycle (WREADY from registered full flag).

## Timing
- Reset values: AWREADY=1, WREADY=0, BVALID=0, BRESP=0, BID=0, SIF_WR_VALID=0, SIF_WR_LAST=0, SIF_WR_DATA/STRB=0; FIFO flushed, counters and err cleared.
- AW handshake at edge N → WREADY may be 1 from cycle N+1.
- W beat accepted at edge N → visible on SIF_WR_* from cycle N+1 (1-cycle latency).
- Final beat popped by SIF at edge N → DRAIN sees empty, BVALID=1 from cycle N+2 at the latest, N+1 minimum; must not precede the final pop.
- RESP → IDLE on edge with BREADY; AWREADY=1 the following cycle. Minimum burst turnaround: single-beat burst with SIF_WR_READY=1 and BREADY=1 completes AW-to-AW in ≤ 5 cycles.
- Reset asserted mid-burst: all state and FIFO contents discarded immediately; no B response issued for the aborted burst.

## Test plan
- Single beat: AWLEN=0, AWID=3, one W beat WLAST=1, SIF_WR_READY=1 → one SIF entry with SIF_WR_LAST=1, then BVALID with BID=3, BRESP=00.
- AWLEN=3, SIF_WR_READY toggling 1/0 each cycle → 4 SIF pops in order with correct data/strobes, SIF_WR_LAST only on 4th, BRESP=00 only after 4th pop.
- AWLEN=39, SIF_WR_READY=0 → WREADY drops after 32 beats; raise SIF_WR_READY → remaining 8 beats accepted, 40 pops total, one B response.
- AWLEN=3, WLAST=1 on beat 2 → all 4 beats still accepted and forwarded, BRESP=2'b10.
- BREADY held low 10 cycles → BVALID/BRESP/BID stable, AWREADY=0 throughout; AW accepted only after B handshake.
- ARESETn pulsed low after 2 of 8 beats → all outputs at reset values, SIF_WR_VALID=0, no BVALID; subsequent AWLEN=0 burst completes normally.
